// File: rtl/nexi_cache_linefill_if.sv
`timescale 1ns/1ps
// Wishbone classic bus bundle for the cache line-fill engine.
// Signal names carry the master's point of view: *_o driven by the master, *_i by the slave.
//   bus_addr_o  byte address of the current word
//   bus_data_o  write data (writeback only)
//   bus_cyc_o   cycle in progress
//   bus_stb_o   strobe
//   bus_we_o    write enable
//   bus_sel_o   byte select (single-bit, whole word)
//   bus_data_i  read data
//   bus_ack_i   transfer acknowledge
//   bus_err_i   transfer error
//   bus_rty_i   retry request
interface nexi_cache_linefill_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] bus_addr_o;
  logic [DATA_WIDTH-1:0] bus_data_o;
  logic                  bus_cyc_o;
  logic                  bus_stb_o;
  logic                  bus_we_o;
  logic                  bus_sel_o;
  logic [DATA_WIDTH-1:0] bus_data_i;
  logic                  bus_ack_i;
  logic                  bus_err_i;
  logic                  bus_rty_i;

  modport master (
    output bus_addr_o, bus_data_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
    input  bus_data_i, bus_ack_i, bus_err_i, bus_rty_i
  );

  modport slave (
    input  bus_addr_o, bus_data_o, bus_cyc_o, bus_stb_o, bus_we_o, bus_sel_o,
    output bus_data_i, bus_ack_i, bus_err_i, bus_rty_i
  );
endinterface

// File: rtl/nexi_cache_linefill.sv
`timescale 1ns/1ps
// Cache line-fill / writeback engine. Moves one whole cache line over a Wishbone classic
// master port, one word per acknowledged cycle, with bounded retry and error abort.
// Ports:
//   clk_i, reset_ni       clock and asynchronous active-low reset
//   req_i, req_we_i       line request (sampled in idle only); 1 = writeback, 0 = fill
//   req_addr_i            any byte address inside the target line
//   wb_data_i             writeback word, selected externally by word_idx_o
//   word_idx_o            index of the word currently on the bus
//   fill_data_o/_idx_o    registered fill word and its index, valid while fill_valid_o
//   fill_valid_o          one-cycle fill strobe
//   busy_o                transfer in progress
//   done_o, err_o         end-of-transfer pulse; err_o marks an aborted transfer
//   bus                   Wishbone master port
module nexi_cache_linefill #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned RETRY_GAP  = 2,
  localparam int unsigned IdxW      = $clog2(LINE_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_i,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic [IdxW-1:0]       word_idx_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic                  fill_valid_o,
  output logic [IdxW-1:0]       fill_idx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  nexi_cache_linefill_if.master bus
);

  localparam int unsigned OffW = IdxW + 2;
  localparam int unsigned RtyW = (MAX_RETRY >= 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned GapW = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StGap, StDone} state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-OffW-1:0]   base_q, base_d;
  logic                         we_q, we_d;
  logic [IdxW-1:0]              idx_q, idx_d;
  logic [RtyW-1:0]              rty_q, rty_d;
  logic [GapW-1:0]              gap_q, gap_d;
  logic                         err_q, err_d;
  logic [DATA_WIDTH-1:0]        fill_data_q, fill_data_d;
  logic                         fill_valid_q, fill_valid_d;
  logic [IdxW-1:0]              fill_idx_q, fill_idx_d;

  // Offset bits inside the line are implied by the word index.
  logic unused_req_addr;
  assign unused_req_addr = ^req_addr_i[OffW-1:0];

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      base_q       <= '0;
      we_q         <= 1'b0;
      idx_q        <= '0;
      rty_q        <= '0;
      gap_q        <= '0;
      err_q        <= 1'b0;
      fill_data_q  <= '0;
      fill_valid_q <= 1'b0;
      fill_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      we_q         <= we_d;
      idx_q        <= idx_d;
      rty_q        <= rty_d;
      gap_q        <= gap_d;
      err_q        <= err_d;
      fill_data_q  <= fill_data_d;
      fill_valid_q <= fill_valid_d;
      fill_idx_q   <= fill_idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    we_d         = we_q;
    idx_d        = idx_q;
    rty_d        = rty_q;
    gap_d        = gap_q;
    err_d        = err_q;
    fill_data_d  = fill_data_q;
    fill_valid_d = 1'b0;
    fill_idx_d   = fill_idx_q;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          base_d  = req_addr_i[ADDR_WIDTH-1:OffW];
          we_d    = req_we_i;
          idx_d   = '0;
          rty_d   = '0;
          err_d   = 1'b0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        // Response priority: err over rty over ack.
        if (bus.bus_err_i) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else if (bus.bus_rty_i) begin
          if (rty_q == RtyW'(MAX_RETRY)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            rty_d   = rty_q + 1'b1;
            gap_d   = '0;
            state_d = (RETRY_GAP == 0) ? StXfer : StGap;
          end
        end else if (bus.bus_ack_i) begin
          if (!we_q) begin
            fill_data_d  = bus.bus_data_i;
            fill_valid_d = 1'b1;
            fill_idx_d   = idx_q;
          end
          if (idx_q == IdxW'(LINE_WORDS - 1)) begin
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
            rty_d = '0;
          end
        end
      end
      StGap: begin
        if (gap_q == GapW'(RETRY_GAP - 1)) begin
          state_d = StXfer;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus controls decode straight from the state register so an asynchronous reset
  // drops cyc/stb in the same cycle.
  assign bus.bus_cyc_o  = (state_q == StXfer) || (state_q == StGap);
  assign bus.bus_stb_o  = (state_q == StXfer);
  assign bus.bus_sel_o  = (state_q == StXfer);
  assign bus.bus_we_o   = we_q;
  assign bus.bus_addr_o = {base_q, idx_q, 2'b00};
  assign bus.bus_data_o = (state_q == StXfer) ? wb_data_i : '0;

  assign word_idx_o   = idx_q;
  assign fill_data_o  = fill_data_q;
  assign fill_valid_o = fill_valid_q;
  assign fill_idx_o   = fill_idx_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign err_o        = (state_q == StDone) && err_q;

endmodule
